// File: rtl/ft245_resp_pkg.sv
// rtl/ft245_resp_pkg.sv - shared types and defaults for the FT245 FIFO responder
package ft245_resp_pkg;

    localparam int BUS_W               = 8;
    localparam int DEF_DEPTH_LOG2      = 4;
    localparam int DEF_RECOVERY_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_ACT,
        ST_WR_ACT,
        ST_RECOVER
    } eng_state_e;

endpackage

// File: rtl/ept_sync_fifo.sv
// rtl/ept_sync_fifo.sv - synchronous FIFO with level output and first-word fall-through head
module ept_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      push_data_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      head_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   level_q;
    logic [DEPTH_LOG2:0]   level_d;
    logic                  push_ok;
    logic                  pop_ok;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_FULL);
    assign pop_ok  = pop_i && !empty_o;
    // A pop on the same edge frees the slot a full FIFO would otherwise refuse.
    assign push_ok = push_i && (!full_o || pop_ok);
    assign level_d = level_q + (DEPTH_LOG2 + 1)'(push_ok) - (DEPTH_LOG2 + 1)'(pop_ok);
    assign level_o = level_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/ft245_fifo_responder.sv
// rtl/ft245_fifo_responder.sv - FT245 device-side model; FT245_RESP_PROTO_CHECK_EN enables PROTO_ERR
module ft245_fifo_responder
    import ft245_resp_pkg::*;
#(
    parameter int DEPTH_LOG2      = DEF_DEPTH_LOG2,
    parameter int RECOVERY_CYCLES = DEF_RECOVERY_CYCLES
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    output logic                 USB_RXF_N,
    output logic                 USB_TXE_N,
    input  logic                 USB_RD_N,
    input  logic                 USB_WR,
    inout  wire  [BUS_W-1:0]     USB_DATA,
    input  logic [BUS_W-1:0]     HOST_RX_DATA,
    input  logic                 HOST_RX_VALID,
    output logic                 HOST_RX_READY,
    output logic [BUS_W-1:0]     HOST_TX_DATA,
    output logic                 HOST_TX_VALID,
    input  logic                 HOST_TX_READY,
    output logic [DEPTH_LOG2:0]  RX_LEVEL,
    output logic [DEPTH_LOG2:0]  TX_LEVEL,
    output logic                 PROTO_ERR
);

    localparam logic [3:0] RCV_LOAD = 4'(RECOVERY_CYCLES - 1);

    eng_state_e        state_q;
    logic [3:0]        rcv_cnt_q;
    logic              rd_n_prev_q;
    logic              wr_prev_q;
    logic              rxf_n_q;
    logic              txe_n_q;
    logic              drive_q;
    logic              host_up_q;
    logic [BUS_W-1:0]  wr_byte_q;

    logic              rd_fall;
    logic              wr_rise;
    logic              rx_push;
    logic              rx_pop;
    logic              tx_push;
    logic              tx_pop;
    logic              rx_full;
    logic              rx_empty;
    logic              tx_full;
    logic              tx_empty;
    logic [BUS_W-1:0]  rx_head;
    logic [BUS_W-1:0]  tx_head;

    assign rd_fall = rd_n_prev_q && !USB_RD_N;
    assign wr_rise = !wr_prev_q && USB_WR;
    assign rx_pop  = (state_q == ST_RD_ACT) && USB_RD_N;
    assign tx_push = (state_q == ST_WR_ACT) && !USB_WR;
    assign rx_push = HOST_RX_VALID && HOST_RX_READY;
    assign tx_pop  = HOST_TX_READY && HOST_TX_VALID;

    assign HOST_RX_READY = host_up_q && !rx_full;
    assign HOST_TX_VALID = !tx_empty;
    assign HOST_TX_DATA  = tx_head;
    assign USB_RXF_N     = rxf_n_q;
    assign USB_TXE_N     = txe_n_q;
    assign USB_DATA      = (drive_q && !rx_empty) ? rx_head : {BUS_W{1'bz}};

    ept_sync_fifo #(.WIDTH(BUS_W), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk         (CLK),
        .resetn      (RST_N),
        .push_i      (rx_push),
        .push_data_i (HOST_RX_DATA),
        .pop_i       (rx_pop),
        .head_o      (rx_head),
        .level_o     (RX_LEVEL),
        .full_o      (rx_full),
        .empty_o     (rx_empty)
    );

    ept_sync_fifo #(.WIDTH(BUS_W), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk         (CLK),
        .resetn      (RST_N),
        .push_i      (tx_push),
        .push_data_i (wr_byte_q),
        .pop_i       (tx_pop),
        .head_o      (tx_head),
        .level_o     (TX_LEVEL),
        .full_o      (tx_full),
        .empty_o     (tx_empty)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            rcv_cnt_q   <= '0;
            rd_n_prev_q <= 1'b1;
            wr_prev_q   <= 1'b0;
            rxf_n_q     <= 1'b1;
            txe_n_q     <= 1'b1;
            drive_q     <= 1'b0;
            host_up_q   <= 1'b0;
            wr_byte_q   <= '0;
        end else begin
            rd_n_prev_q <= USB_RD_N;
            wr_prev_q   <= USB_WR;
            host_up_q   <= 1'b1;
            rxf_n_q     <= rx_empty;
            txe_n_q     <= tx_full;
            case (state_q)
                ST_IDLE: begin
                    // Simultaneous RD/WR starts nothing; strobes start only on their edge.
                    if (USB_RD_N || !USB_WR) begin
                        if (rd_fall && !rxf_n_q) begin
                            state_q <= ST_RD_ACT;
                            drive_q <= 1'b1;
                        end else if (wr_rise && !txe_n_q) begin
                            state_q   <= ST_WR_ACT;
                            wr_byte_q <= USB_DATA;
                        end
                    end
                end
                ST_RD_ACT: begin
                    if (USB_RD_N) begin
                        state_q   <= ST_RECOVER;
                        rcv_cnt_q <= RCV_LOAD;
                        drive_q   <= 1'b0;
                        rxf_n_q   <= 1'b1;
                        txe_n_q   <= 1'b1;
                    end
                end
                ST_WR_ACT: begin
                    if (USB_WR) begin
                        wr_byte_q <= USB_DATA;
                    end else begin
                        state_q   <= ST_RECOVER;
                        rcv_cnt_q <= RCV_LOAD;
                        rxf_n_q   <= 1'b1;
                        txe_n_q   <= 1'b1;
                    end
                end
                ST_RECOVER: begin
                    if (rcv_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        rcv_cnt_q <= rcv_cnt_q - 4'd1;
                        rxf_n_q   <= 1'b1;
                        txe_n_q   <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef FT245_RESP_PROTO_CHECK_EN
    logic illegal;
    logic err_q;

    always_comb begin
        illegal = 1'b0;
        case (state_q)
            ST_IDLE:    illegal = (!USB_RD_N && USB_WR) || (rd_fall && rxf_n_q) || (wr_rise && txe_n_q);
            ST_RECOVER: illegal = rd_fall || wr_rise;
            default:    illegal = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N)       err_q <= 1'b0;
        else if (illegal) err_q <= 1'b1;
    end

    assign PROTO_ERR = err_q;
`else
    assign PROTO_ERR = 1'b0;
`endif

endmodule
